filter_window_seq: RTL and testbench

Frame-scan sequencer that drives the 3x3 effect filters (colour inversion and similar) in the image-effects datapath. It reads a 12-bit RGB444 source frame from a synchronous RAM one neighbourhood at a time and packs the nine pixels into the 108-bit window bus the filters consume. It then tracks the filter's fixed pipeline latency and writes each filtered pixel to the destination RAM at the matching address. The block sits between the frame buffers and whichever effect module is instantiated.

---
 rtl/filter_window_seq_pkg.sv | 40 ++++
 rtl/filter_window_seq_if.sv | 33 +++
 rtl/filter_seq_delay.sv | 28 ++
 rtl/filter_window_seq.sv | 171 +++++++++++++++++
 tb/tb_filter_window_seq.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/filter_window_seq_pkg.sv
// Shared types for the 3x3 window sequencer: pixel/window widths,
// neighbourhood slot order with bit offsets, and FSM states.
package filter_seq_pkg;

    localparam int PIX_W = 12;
    localparam int WIN_W = 9 * PIX_W;

    // Slot order is also the packing order on the window bus, MSB first.
    typedef enum logic [3:0] {
        SLOT_ORIG, SLOT_L, SLOT_R, SLOT_U, SLOT_D,
        SLOT_UL, SLOT_UR, SLOT_DL, SLOT_DR
    } slot_e;

    typedef enum logic [1:0] {IDLE, FETCH, LAST, DRAIN} state_e;

    // Neighbour step along one axis.
    typedef enum logic [1:0] {D_ZERO, D_NEG, D_POS} dir_e;

    // LSB position of a slot inside the window bus.
    function automatic int slot_off(slot_e s);
        return (int'(SLOT_DR) - int'(s)) * PIX_W;
    endfunction

    function automatic dir_e slot_dx(slot_e s);
        case (s)
            SLOT_L, SLOT_UL, SLOT_DL: return D_NEG;
            SLOT_R, SLOT_UR, SLOT_DR: return D_POS;
            default:                  return D_ZERO;
        endcase
    endfunction

    function automatic dir_e slot_dy(slot_e s);
        case (s)
            SLOT_U, SLOT_UL, SLOT_UR: return D_NEG;
            SLOT_D, SLOT_DL, SLOT_DR: return D_POS;
            default:                  return D_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/filter_window_seq_if.sv
// Frame-buffer / filter bus of the window sequencer.
// master: the sequencer side; slave: RAMs, filter and controller side.
interface filter_window_seq_if #(
    parameter int ADDR_W = 15
);
    import filter_seq_pkg::*;

    logic              start;
    logic              busy;
    logic              done;
    logic              src_rd;
    logic [ADDR_W-1:0] src_addr;
    logic [PIX_W-1:0]  src_data;
    logic [WIN_W-1:0]  color_data;
    logic              win_valid;
    logic [PIX_W-1:0]  filter_rgb_in;
    logic              dst_we;
    logic [ADDR_W-1:0] dst_addr;
    logic [PIX_W-1:0]  dst_data;

    modport master (
        input  start, src_data, filter_rgb_in,
        output busy, done, src_rd, src_addr, color_data, win_valid,
               dst_we, dst_addr, dst_data
    );

    modport slave (
        output start, src_data, filter_rgb_in,
        input  busy, done, src_rd, src_addr, color_data, win_valid,
               dst_we, dst_addr, dst_data
    );

endinterface

// File: rtl/filter_seq_delay.sv
// Fixed-latency {valid, address} delay line that tracks the filter pipeline.
module filter_seq_delay #(
    parameter int LAT    = 4,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_vld,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_vld,
    output logic [ADDR_W-1:0] o_addr
);

    logic [LAT-1:0][ADDR_W:0] r_pipe;

    // shift {valid, address} one stage per cycle; reset drops in-flight writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= {i_vld, i_addr};
            for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign {o_vld, o_addr} = r_pipe[LAT-1];

endmodule

// File: rtl/filter_window_seq.sv
// Frame-scan sequencer: fetches each 3x3 neighbourhood from the source RAM,
// presents it as one window to the filter, and writes the filter result to
// the destination RAM after FILTER_LAT cycles.
// Optional build macro FILTER_SEQ_BORDER_ZERO_EN: out-of-frame neighbours
// read as zero (no RAM read) instead of replicating the edge pixel.
module filter_window_seq
    import filter_seq_pkg::*;
#(
    parameter int IMG_W      = 160,
    parameter int IMG_H      = 120,
    parameter int ADDR_W     = 15,
    parameter int FILTER_LAT = 4
) (
    input  logic               clk,
    input  logic               reset,
    filter_window_seq_if.master bus
);

`ifdef FILTER_SEQ_BORDER_ZERO_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] A_ONE    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] W_M1     = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] H_M1     = ADDR_W'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_W * IMG_H - 1);

    state_e            r_state, w_state_nxt;
    slot_e             r_slot, r_cap_slot;
    logic [ADDR_W-1:0] r_x, r_y, r_row;
    logic              r_cap_vld, r_cap_zero;
    logic [WIN_W-1:0]  r_shadow, w_shadow_nxt, r_color;
    logic              r_win_valid, r_done, w_done_nxt;
    logic [ADDR_W-1:0] r_win_addr;
    logic [ADDR_W-1:0] w_col, w_rowb, w_rd_addr;
    logic              w_oob, w_rd, w_last_pix;
    logic              w_dly_vld;
    logic [ADDR_W-1:0] w_dly_addr;

    assign w_last_pix = (r_x == W_M1) && (r_y == H_M1);

    // clamped neighbour address of the current slot; row base stepped by IMG_W
    always_comb begin
        w_col  = r_x;
        w_rowb = r_row;
        w_oob  = 1'b0;
        case (slot_dx(r_slot))
            D_NEG:   if (r_x == '0)  w_oob = 1'b1; else w_col = r_x - A_ONE;
            D_POS:   if (r_x == W_M1) w_oob = 1'b1; else w_col = r_x + A_ONE;
            default: ;
        endcase
        case (slot_dy(r_slot))
            D_NEG:   if (r_y == '0)  w_oob = 1'b1; else w_rowb = r_row - ROW_STEP;
            D_POS:   if (r_y == H_M1) w_oob = 1'b1; else w_rowb = r_row + ROW_STEP;
            default: ;
        endcase
        w_rd_addr = w_rowb + w_col;
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // next state, read strobe and frame-complete detect
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        w_rd        = (r_state == FETCH) && !(ZERO_EN && w_oob);
        case (r_state)
            IDLE:  if (bus.start) w_state_nxt = FETCH;
            FETCH: if (r_slot == SLOT_DR) w_state_nxt = LAST;
            LAST:  w_state_nxt = w_last_pix ? DRAIN : FETCH;
            DRAIN: if (w_dly_vld && (w_dly_addr == LAST_PIX)) begin
                w_state_nxt = IDLE;
                w_done_nxt  = 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // raster position and slot counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x    <= '0;
            r_y    <= '0;
            r_row  <= '0;
            r_slot <= SLOT_ORIG;
        end else begin
            case (r_state)
                IDLE: begin
                    r_x    <= '0;
                    r_y    <= '0;
                    r_row  <= '0;
                    r_slot <= SLOT_ORIG;
                end
                FETCH: if (r_slot != SLOT_DR) r_slot <= slot_e'(r_slot + 4'd1);
                LAST: begin
                    r_slot <= SLOT_ORIG;
                    if (r_x == W_M1) begin
                        r_x   <= '0;
                        r_y   <= r_y + A_ONE;
                        r_row <= r_row + ROW_STEP;
                    end else begin
                        r_x <= r_x + A_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // merge the pixel returned for the previous slot into the shadow window
    always_comb begin
        w_shadow_nxt = r_shadow;
        if (r_cap_vld)
            w_shadow_nxt[slot_off(r_cap_slot) +: PIX_W] = r_cap_zero ? '0 : bus.src_data;
    end

    // capture pipeline, window publish and done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cap_vld   <= 1'b0;
            r_cap_zero  <= 1'b0;
            r_cap_slot  <= SLOT_ORIG;
            r_shadow    <= '0;
            r_color     <= '0;
            r_win_valid <= 1'b0;
            r_win_addr  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_cap_vld   <= (r_state == FETCH);
            r_cap_slot  <= r_slot;
            r_cap_zero  <= ZERO_EN && w_oob;
            r_shadow    <= w_shadow_nxt;
            r_win_valid <= (r_state == LAST);
            r_done      <= w_done_nxt;
            if (r_state == LAST) begin
                r_color    <= w_shadow_nxt;
                r_win_addr <= r_row + r_x;
            end
        end
    end

    filter_seq_delay #(
        .LAT    (FILTER_LAT),
        .ADDR_W (ADDR_W)
    ) u_dly (
        .clk    (clk),
        .reset  (reset),
        .i_vld  (r_win_valid),
        .i_addr (r_win_addr),
        .o_vld  (w_dly_vld),
        .o_addr (w_dly_addr)
    );

    assign bus.busy       = (r_state != IDLE);
    assign bus.done       = r_done;
    assign bus.src_rd     = w_rd;
    assign bus.src_addr   = w_rd ? w_rd_addr : '0;
    assign bus.color_data = r_color;
    assign bus.win_valid  = r_win_valid;
    assign bus.dst_we     = w_dly_vld;
    assign bus.dst_addr   = w_dly_addr;
    assign bus.dst_data   = bus.filter_rgb_in;

endmodule

// File: tb/tb_filter_window_seq.sv
// Bench for filter_window_seq on a 4x3 frame with a colour-inversion filter
// model (latency 4). Expected outputs come from a frame-level model driven by
// the cycle offset from each accepted start.
module tb_filter_window_seq;

`ifdef FILTER_SEQ_BORDER_ZERO_EN
    localparam bit ZB = 1'b1;
`else
    localparam bit ZB = 1'b0;
`endif

    localparam int W   = 4;
    localparam int H   = 3;
    localparam int N   = W * H;
    localparam int LAT = 4;
    localparam int END = 10 * N + 2 + LAT;   // done cycle relative to start

    typedef struct {
        bit          busy, rd, wv, we, done, has_win;
        int          saddr, daddr;
        logic [11:0] ddata;
        logic [107:0] win;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    filter_window_seq_if #(.ADDR_W(15)) bus ();

    filter_window_seq #(
        .IMG_W(W), .IMG_H(H), .ADDR_W(15), .FILTER_LAT(LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [11:0] mem [N];
    int DX [9] = '{0, -1, 1, 0, 0, -1, 1, -1, 1};
    int DY [9] = '{0, 0, 0, -1, 1, -1, -1, 1, 1};

    int cyc = 0;
    int fr_s, fr_prev, phase;
    int n_chk = 0, n_fail = 0;
    int wr_cnt [10];
    int dn_cnt [10];
    bit fin = 1'b0;
    logic [107:0] last_win = '0;
    logic [3:0][11:0] fpipe = '0;

    always @(posedge clk) cyc++;

    // source RAM: synchronous read
    always @(posedge clk)
        if (bus.src_rd)
            bus.src_data <= (int'(bus.src_addr) < N) ? mem[int'(bus.src_addr)] : 12'hBAD;

    // colour-inversion filter with 4-cycle latency
    always @(posedge clk) fpipe <= {fpipe[2:0], ~bus.color_data[107:96]};
    assign bus.filter_rgb_in = fpipe[3];

    function automatic void nb(input int p, input int k, output int addr, output bit oob);
        int nx, ny;
        nx = p % W + DX[k];
        ny = p / W + DY[k];
        oob = 1'b0;
        if (nx < 0)  begin nx = 0;     oob = 1'b1; end
        if (nx >= W) begin nx = W - 1; oob = 1'b1; end
        if (ny < 0)  begin ny = 0;     oob = 1'b1; end
        if (ny >= H) begin ny = H - 1; oob = 1'b1; end
        addr = ny * W + nx;
    endfunction

    function automatic logic [107:0] window(input int p);
        logic [107:0] w;
        int a;
        bit o;
        w = '0;
        for (int k = 0; k < 9; k++) begin
            nb(p, k, a, o);
            w[107 - 12*k -: 12] = (ZB && o) ? 12'h000 : mem[a];
        end
        return w;
    endfunction

    // what the block must show in cycle c for a frame started in cycle s
    function automatic void frame_exp(input int s, input int c, output exp_t e);
        int r, p, ph, n, a;
        bit o;
        e = '{default: '0};
        if (s < 0) return;
        r = c - s;
        if (r < 1 || r > END) return;
        e.busy = (r < END);
        e.done = (r == END);
        if (r <= 10 * N) begin
            p  = (r - 1) / 10;
            ph = (r - 1) % 10;
            if (ph < 9) begin
                nb(p, ph, a, o);
                e.rd    = !(ZB && o);
                e.saddr = a;
            end
        end
        if (r >= 11 && (r - 11) % 10 == 0 && (r - 11) / 10 < N) begin
            e.wv = 1'b1;
            e.has_win = 1'b1;
            e.win = window((r - 11) / 10);
        end
        if (r >= 11 + LAT && (r - 11 - LAT) % 10 == 0 && (r - 11 - LAT) / 10 < N) begin
            n = (r - 11 - LAT) / 10;
            e.we    = 1'b1;
            e.daddr = n;
            e.ddata = ~mem[n];
        end
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    exp_t ea, eb, e;
    int rr;

    // compare process
    always @(negedge clk) begin
        if (reset) begin
            chk("rst_busy", bus.busy, 0);
            chk("rst_done", bus.done, 0);
            chk("rst_src_rd", bus.src_rd, 0);
            chk("rst_win_valid", bus.win_valid, 0);
            chk("rst_dst_we", bus.dst_we, 0);
            chk("rst_src_addr", bus.src_addr, 0);
            chk("rst_dst_addr", bus.dst_addr, 0);
            chk("rst_color", bus.color_data, 0);
            last_win = '0;
        end else begin
            frame_exp(fr_prev, cyc, ea);
            frame_exp(fr_s, cyc, eb);
            e = eb;
            e.busy |= ea.busy; e.done |= ea.done;
            if (ea.rd) begin e.rd = 1'b1; e.saddr = ea.saddr; end
            if (ea.has_win) begin e.wv = 1'b1; e.has_win = 1'b1; e.win = ea.win; end
            if (ea.we) begin e.we = 1'b1; e.daddr = ea.daddr; e.ddata = ea.ddata; end
            if (e.has_win) last_win = e.win;

            chk("busy", bus.busy, e.busy);
            chk("done", bus.done, e.done);
            chk("src_rd", bus.src_rd, e.rd);
            chk("win_valid", bus.win_valid, e.wv);
            chk("dst_we", bus.dst_we, e.we);
            chk("color_data", bus.color_data, last_win);
            if (e.rd) chk("src_addr", bus.src_addr, 15'(e.saddr));
            if (e.we) begin
                chk("dst_addr", bus.dst_addr, 15'(e.daddr));
                chk("dst_data", bus.dst_data, e.ddata);
            end

            if (bus.dst_we) wr_cnt[phase]++;
            if (bus.done)   dn_cnt[phase]++;

            // hand-computed anchors
            rr = cyc - fr_s;
            if (fr_s >= 0 && phase == 1 && rr == 11)
                chk("lit_win_00", bus.color_data, ZB ?
                    108'h000_000_001_000_004_000_000_000_005 :
                    108'h000_000_001_000_004_000_001_004_005);
            if (fr_s >= 0 && phase == 1 && rr == 61)
                chk("lit_win_11", bus.color_data, 108'h005_004_006_001_009_000_002_008_00A);
            if (fr_s >= 0 && phase == 2 && rr == 15) begin
                chk("lit_we15", bus.dst_we, 1);
                chk("lit_addr15", bus.dst_addr, 0);
                chk("lit_data15", bus.dst_data, 12'hEDC);
            end
            if (fr_s >= 0 && phase == 2 && rr == 125) begin
                chk("lit_we125", bus.dst_we, 1);
                chk("lit_addr125", bus.dst_addr, 11);
            end
            if (fr_s >= 0 && phase == 2 && rr == 126) begin
                chk("lit_done126", bus.done, 1);
                chk("lit_busy126", bus.busy, 0);
            end
            if (phase == 8 && !fin) begin
                fin = 1'b1;
                chk("restart_ignored_writes", wr_cnt[3], 12);
                chk("restart_ignored_dones", dn_cnt[3], 1);
                chk("post_reset_writes", wr_cnt[4], 0);
                chk("post_reset_dones", dn_cnt[4], 0);
                chk("rerun_writes", wr_cnt[6], 12);
                chk("b2b_writes", wr_cnt[7], 12);
                chk("b2b_dones", dn_cnt[7], 1);
            end
        end
    end

    task automatic do_start(input int ph);
        @(posedge clk);
        #2;
        bus.start = 1'b1;
        phase     = ph;
        fr_prev   = fr_s;
        fr_s      = cyc;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        fr_s      = -1;
        fr_prev   = -1;
        phase     = 0;
        for (int i = 0; i < 10; i++) begin wr_cnt[i] = 0; dn_cnt[i] = 0; end
        for (int a = 0; a < N; a++) mem[a] = 12'(a);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);

        // ramp frame
        do_start(1);
        repeat (END + 3) @(posedge clk);

        // inversion frame with 0x123 at address 0
        mem[0] = 12'h123;
        do_start(2);
        repeat (END + 3) @(posedge clk);

        // start pulsed again at cycle 50 of an active frame
        do_start(3);
        repeat (49) @(posedge clk);
        #2 bus.start = 1'b1;
        @(posedge clk);
        #2 bus.start = 1'b0;
        repeat (END) @(posedge clk);

        // reset at cycle 40 aborts the frame
        do_start(5);
        repeat (39) @(posedge clk);
        #2;
        reset   = 1'b1;
        fr_s    = -1;
        fr_prev = -1;
        phase   = 4;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        repeat (150) @(posedge clk);

        // full frame after reset, then a back-to-back frame
        do_start(6);
        repeat (END - 1) @(posedge clk);
        do_start(7);
        repeat (END + 3) @(posedge clk);

        phase = 8;
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
